// File: rtl/ecc_path_arbiter.sv
// ECC path arbiter: one shared ECC generator serving a write-encode path and
// a read-check path, with alternating priority and a saturating error counter.

// Hamming-style ECC over 64 data bits. Data bit i occupies the i-th
// non-power-of-two position (3,5,6,7,9,...). Check bit k (0..6) is the XOR of
// the data bits whose position has bit k set. Bit 7 is the XOR of all data bits.
module ecc_generator (
   input  logic [63:0] data,
   output logic [7:0]  ecc
);

   localparam int unsigned DATA_W = 64;
   localparam int unsigned POS_W  = 7;

   // Position of data bit idx within the Hamming codeword.
   function automatic logic [POS_W-1:0] data_pos(input int unsigned idx);
      int unsigned cnt;
      data_pos = '0;
      cnt      = 0;
      for (int unsigned q = 1; q < 128; q++) begin
         if ((q & (q - 1)) != 0) begin
            if (cnt == idx) data_pos = POS_W'(q);
            cnt++;
         end
      end
   endfunction

   // Fold every data bit into the check bits its position selects.
   always_comb begin
      logic [POS_W-1:0] pos;
      ecc = '0;
      pos = '0;
      for (int i = 0; i < DATA_W; i++) begin
         pos = data_pos(i);
         for (int k = 0; k < POS_W; k++) begin
            ecc[k] = ecc[k] ^ (data[i] & pos[k]);
         end
         ecc[7] = ecc[7] ^ data[i];
      end
   end

endmodule

module ecc_path_arbiter #(
   parameter int unsigned ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_valid,
   input  logic [63:0]          wr_data,
   output logic                 wr_ready,
   output logic                 wr_rsp_valid,
   output logic [7:0]           wr_rsp_ecc,
   input  logic                 wr_rsp_ready,
   input  logic                 rd_valid,
   input  logic [63:0]          rd_data,
   input  logic [7:0]           rd_ecc,
   output logic                 rd_ready,
   output logic                 rd_rsp_valid,
   output logic                 rd_rsp_err,
   output logic [7:0]           rd_rsp_syndrome,
   input  logic                 rd_rsp_ready,
   input  logic                 err_clr,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic {
      PRI_WR = 1'b0,
      PRI_RD = 1'b1
   } pri_t;

   pri_t        state_q, state_d;
   logic        wr_elig_c, rd_elig_c;
   logic        grant_wr_c, grant_rd_c;
   logic [63:0] enc_in_c;
   logic [7:0]  enc_ecc_c;
   logic [7:0]  syndrome_c;

   // A path may be granted when its output register is empty or draining now.
   assign wr_elig_c = wr_valid && (!wr_rsp_valid || wr_rsp_ready);
   assign rd_elig_c = rd_valid && (!rd_rsp_valid || rd_rsp_ready);

   // Priority state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= PRI_WR;
      else        state_q <= state_d;
   end

   // Grant selection and priority hand-over to the path that lost this cycle.
   always_comb begin
      state_d    = state_q;
      grant_wr_c = 1'b0;
      grant_rd_c = 1'b0;
      if (wr_elig_c && (!rd_elig_c || state_q == PRI_WR)) begin
         grant_wr_c = 1'b1;
      end else if (rd_elig_c) begin
         grant_rd_c = 1'b1;
      end
      if (grant_wr_c)      state_d = PRI_RD;
      else if (grant_rd_c) state_d = PRI_WR;
   end

   assign wr_ready = grant_wr_c;
   assign rd_ready = grant_rd_c;

   // Shared generator sees the granted path's data.
   assign enc_in_c   = grant_wr_c ? wr_data : rd_data;
   assign syndrome_c = enc_ecc_c ^ rd_ecc;

   ecc_generator u_ecc_generator (
      .data (enc_in_c),
      .ecc  (enc_ecc_c)
   );

   // Write output register: load on grant, clear on drain, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_rsp_valid <= 1'b0;
         wr_rsp_ecc   <= '0;
      end else if (grant_wr_c) begin
         wr_rsp_valid <= 1'b1;
         wr_rsp_ecc   <= enc_ecc_c;
      end else if (wr_rsp_ready) begin
         wr_rsp_valid <= 1'b0;
      end
   end

   // Read output register: load on grant, clear on drain, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_rsp_valid    <= 1'b0;
         rd_rsp_err      <= 1'b0;
         rd_rsp_syndrome <= '0;
      end else if (grant_rd_c) begin
         rd_rsp_valid    <= 1'b1;
         rd_rsp_err      <= |syndrome_c;
         rd_rsp_syndrome <= syndrome_c;
      end else if (rd_rsp_ready) begin
         rd_rsp_valid <= 1'b0;
      end
   end

   // Saturating mismatch counter; clear wins over a coincident increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if (grant_rd_c && (|syndrome_c) && (err_count != {ERR_CNT_W{1'b1}})) begin
         err_count <= err_count + ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ecc_path_arbiter.sv
// Directed bench for ecc_path_arbiter with hand-computed expected values.
module tb_ecc_path_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid, wr_rsp_ready, rd_valid, rd_rsp_ready, err_clr;
   logic [63:0] wr_data, rd_data;
   logic [7:0]  rd_ecc;

   logic        wr_ready, wr_rsp_valid, rd_ready, rd_rsp_valid, rd_rsp_err;
   logic [7:0]  wr_rsp_ecc, rd_rsp_syndrome;
   logic [15:0] err_count;

   logic        wr_ready2, wr_rsp_valid2, rd_ready2, rd_rsp_valid2, rd_rsp_err2;
   logic [7:0]  wr_rsp_ecc2, rd_rsp_syndrome2;
   logic [1:0]  err_count2;

   int n_chk = 0;
   int n_err = 0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   always #5 clk = ~clk;

   ecc_path_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .wr_rsp_valid(wr_rsp_valid), .wr_rsp_ecc(wr_rsp_ecc), .wr_rsp_ready(wr_rsp_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ecc(rd_ecc), .rd_ready(rd_ready),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_err(rd_rsp_err),
      .rd_rsp_syndrome(rd_rsp_syndrome), .rd_rsp_ready(rd_rsp_ready),
      .err_clr(err_clr), .err_count(err_count)
   );

   ecc_path_arbiter #(.ERR_CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready2),
      .wr_rsp_valid(wr_rsp_valid2), .wr_rsp_ecc(wr_rsp_ecc2), .wr_rsp_ready(wr_rsp_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ecc(rd_ecc), .rd_ready(rd_ready2),
      .rd_rsp_valid(rd_rsp_valid2), .rd_rsp_err(rd_rsp_err2),
      .rd_rsp_syndrome(rd_rsp_syndrome2), .rd_rsp_ready(rd_rsp_ready),
      .err_clr(err_clr), .err_count(err_count2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      wr_valid = 1'b0; wr_data = '0; wr_rsp_ready = 1'b1;
      rd_valid = 1'b0; rd_data = '0; rd_ecc = '0; rd_rsp_ready = 1'b1;
      err_clr = 1'b0;
      #3;
      check("rst_wr_valid", 64'(wr_rsp_valid), 64'd0);
      check("rst_rd_valid", 64'(rd_rsp_valid), 64'd0);
      check("rst_err_count", 64'(err_count), 64'd0);
      tick(); tick();
      rst_n = 1'b1;

      // Write-only encodes: 0 -> 00, all-ones -> 7F, bit0 -> 83
      wr_valid = 1'b1; wr_data = 64'd0;
      #1 check("wr_ready_0", 64'(wr_ready), 64'd1);
      tick();
      check("wr_vld_0", 64'(wr_rsp_valid), 64'd1);
      check("wr_ecc_0", 64'(wr_rsp_ecc), 64'h00);
      wr_data = ONES;
      #1 check("wr_ready_1", 64'(wr_ready), 64'd1);
      tick();
      check("wr_ecc_ones", 64'(wr_rsp_ecc), 64'h7F);
      wr_data = 64'd1;
      tick();
      check("wr_ecc_bit0", 64'(wr_rsp_ecc), 64'h83);
      wr_valid = 1'b0;
      tick();
      check("wr_drained", 64'(wr_rsp_valid), 64'd0);

      // Read checks: clean then single-bit ECC error
      rd_valid = 1'b1; rd_data = ONES; rd_ecc = 8'h7F;
      #1 check("rd_ready_0", 64'(rd_ready), 64'd1);
      tick();
      check("rd_vld_0", 64'(rd_rsp_valid), 64'd1);
      check("rd_err_clean", 64'(rd_rsp_err), 64'd0);
      check("rd_syn_clean", 64'(rd_rsp_syndrome), 64'h00);
      check("cnt_clean", 64'(err_count), 64'd0);
      rd_ecc = 8'h7E;
      tick();
      check("rd_err_bad", 64'(rd_rsp_err), 64'd1);
      check("rd_syn_bad", 64'(rd_rsp_syndrome), 64'h01);
      check("cnt_bad", 64'(err_count), 64'd1);
      rd_valid = 1'b0;
      tick();
      check("rd_drained", 64'(rd_rsp_valid), 64'd0);

      // Both requesting every cycle: strict W,R,W,R alternation
      rd_ecc = 8'h7F; wr_valid = 1'b1; rd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("alt_wr_%0d", i), 64'(wr_ready), 64'((i % 2) == 0));
         check($sformatf("alt_rd_%0d", i), 64'(rd_ready), 64'((i % 2) == 1));
         tick();
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
      tick();

      // Write backpressure: hold payload, read proceeds, same-cycle reload
      wr_rsp_ready = 1'b0; wr_valid = 1'b1; wr_data = 64'd0;
      tick();
      check("bp_vld", 64'(wr_rsp_valid), 64'd1);
      check("bp_ecc0", 64'(wr_rsp_ecc), 64'h00);
      wr_data = ONES; rd_valid = 1'b1;
      #1;
      check("bp_wr_ready", 64'(wr_ready), 64'd0);
      check("bp_rd_ready", 64'(rd_ready), 64'd1);
      tick();
      check("bp_ecc_stable", 64'(wr_rsp_ecc), 64'h00);
      check("bp_rd_vld", 64'(rd_rsp_valid), 64'd1);
      rd_valid = 1'b0; wr_rsp_ready = 1'b1;
      #1 check("reload_ready", 64'(wr_ready), 64'd1);
      tick();
      check("reload_vld", 64'(wr_rsp_valid), 64'd1);
      check("reload_ecc", 64'(wr_rsp_ecc), 64'h7F);
      wr_valid = 1'b0;
      tick();

      // Saturation: 16-bit counter keeps counting, 2-bit counter sticks at 3
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("clr_cnt", 64'(err_count), 64'd0);
      check("clr_cnt2", 64'(err_count2), 64'd0);
      rd_valid = 1'b1; rd_data = ONES; rd_ecc = 8'h7E;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("sat_cnt_%0d", i), 64'(err_count), 64'(i + 1));
         check($sformatf("sat_cnt2_%0d", i), 64'(err_count2), 64'((i < 3) ? i + 1 : 3));
      end
      err_clr = 1'b1;
      tick();
      check("clr_wins", 64'(err_count), 64'd0);
      check("clr_wins2", 64'(err_count2), 64'd0);
      err_clr = 1'b0; rd_valid = 1'b0;
      tick();

      // Async reset while both results are held
      wr_rsp_ready = 1'b0; rd_rsp_ready = 1'b0;
      wr_valid = 1'b1; rd_valid = 1'b1; wr_data = ONES;
      tick();
      tick();
      check("pre_rst_wr_vld", 64'(wr_rsp_valid), 64'd1);
      check("pre_rst_rd_vld", 64'(rd_rsp_valid), 64'd1);
      check("pre_rst_cnt", 64'(err_count), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_wr_vld", 64'(wr_rsp_valid), 64'd0);
      check("arst_rd_vld", 64'(rd_rsp_valid), 64'd0);
      check("arst_wr_ecc", 64'(wr_rsp_ecc), 64'd0);
      check("arst_rd_err", 64'(rd_rsp_err), 64'd0);
      check("arst_rd_syn", 64'(rd_rsp_syndrome), 64'd0);
      check("arst_cnt", 64'(err_count), 64'd0);
      tick();
      rst_n = 1'b1; wr_rsp_ready = 1'b1; rd_rsp_ready = 1'b1;
      #1;
      check("post_rst_wr_ready", 64'(wr_ready), 64'd1);
      check("post_rst_rd_ready", 64'(rd_ready), 64'd0);
      tick();
      check("post_rst_wr_vld", 64'(wr_rsp_valid), 64'd1);
      check("post_rst_rd_vld", 64'(rd_rsp_valid), 64'd0);
      wr_valid = 1'b0; rd_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
